// File: rtl/rvm_pc_sequencer.sv
// rvm_pc_sequencer
//
// Fetch/PC sequencing controller for the multi-cycle core. It owns the single
// write port of the PC unit. It runs the instruction-memory request/grant/response
// handshake and holds the fetched word for decode until decode takes it. It then
// waits for execute to retire the instruction. Finally it writes the next PC:
// sequential, branch, or trap vector.
//
// Ports:
//   clk            system clock
//   resetn         asynchronous, active-low reset
//   pc             current PC from the PC unit
//   pc_w_en        one-cycle PC write strobe
//   pc_wdata       next-PC value, valid while pc_w_en is high
//   imem_req       fetch request, held until imem_gnt
//   imem_addr      fetch address (always the current pc, combinational)
//   imem_gnt       request accepted this cycle
//   imem_rvalid    fetch response valid
//   imem_rdata     fetched instruction word
//   imem_err       fetch bus error, qualified by imem_rvalid
//   instr_valid    registered instruction available to decode
//   instr          registered instruction word
//   instr_ready    decode accepts instr
//   retire         execute finished the current instruction
//   branch_taken   qualifies branch_target, sampled with retire
//   branch_target  control-transfer destination
//   trap_req       execute raises a trap, sampled with retire
//   mtvec          trap vector base
//   fault          one-cycle pulse alongside pc_w_en on fetch error or
//                  misaligned branch target
//
// Cycle flow per instruction: FETCH -> WAIT -> HOLD -> EXEC -> UPDATE -> FETCH.
// A fetch error skips HOLD/EXEC and goes straight to UPDATE with the trap target.

module rvm_pc_sequencer #(
    parameter logic [31:0] TRAP_ADDR_MASK = 32'hFFFF_FFFC
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] pc,
    output logic        pc_w_en,
    output logic [31:0] pc_wdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic        instr_valid,
    output logic [31:0] instr,
    input  logic        instr_ready,
    input  logic        retire,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        trap_req,
    input  logic [31:0] mtvec,
    output logic        fault
);

    typedef enum logic [2:0] {
        S_RESET,
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_EXEC,
        S_UPDATE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] trap_target;
    logic [31:0] seq_pc;
    logic [31:0] next_pc;
    logic        next_fault;

    assign trap_target = mtvec & TRAP_ADDR_MASK;
    assign seq_pc      = pc + 32'd4;

    // The fetch address is the PC itself. The PC unit only changes on our own
    // pc_w_en, so it is stable for the whole time imem_req is high.
    assign imem_addr = pc;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_RESET;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and next-PC selection. next_pc defaults to the value already
    // held in pc_wdata. The output register therefore only changes when a new
    // PC is chosen on the way into UPDATE.
    always_comb begin
        state_next = state;
        next_pc    = pc_wdata;
        next_fault = 1'b0;
        case (state)
            S_RESET: begin
                state_next = S_FETCH;
            end
            S_FETCH: begin
                if (imem_gnt) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (imem_err) begin
                        state_next = S_UPDATE;
                        next_pc    = trap_target;
                        next_fault = 1'b1;
                    end else begin
                        state_next = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (retire) begin
                    state_next = S_UPDATE;
                    // A trap outranks any branch. A taken branch to a
                    // non-word-aligned target is turned into a trap with a
                    // fault pulse.
                    if (trap_req) begin
                        next_pc = trap_target;
                    end else if (branch_taken && (branch_target[1:0] != 2'b00)) begin
                        next_pc    = trap_target;
                        next_fault = 1'b1;
                    end else if (branch_taken) begin
                        next_pc = branch_target;
                    end else begin
                        next_pc = seq_pc;
                    end
                end
            end
            S_UPDATE: begin
                state_next = S_FETCH;
            end
            default: begin
                state_next = S_RESET;
            end
        endcase
    end

    // Registered outputs. They are decoded from the next state, so each output
    // is asserted for exactly the cycles spent in its state. Examples:
    // imem_req in FETCH, instr_valid in HOLD, pc_w_en in UPDATE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            pc_w_en     <= 1'b0;
            pc_wdata    <= 32'd0;
            fault       <= 1'b0;
            instr       <= 32'd0;
        end else begin
            imem_req    <= (state_next == S_FETCH);
            instr_valid <= (state_next == S_HOLD);
            pc_w_en     <= (state_next == S_UPDATE);
            pc_wdata    <= next_pc;
            fault       <= next_fault;
            if ((state == S_WAIT) && imem_rvalid && !imem_err) begin
                instr <= imem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_rvm_pc_sequencer.sv
// tb_rvm_pc_sequencer
//
// Directed testbench for rvm_pc_sequencer. A simple PC-unit model captures
// pc_wdata on pc_w_en. The stimulus process plays memory, decode and execute
// for one instruction per vector. For each vector it pushes the expected next
// PC/fault and the expected instruction word into queues. A separate monitor
// process pops those queues when the DUT presents pc_w_en or a rising
// instr_valid.

module tb_rvm_pc_sequencer;

    logic        clk;
    logic        resetn;
    logic [31:0] pc;
    logic        pc_w_en;
    logic [31:0] pc_wdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        retire;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        trap_req;
    logic [31:0] mtvec;
    logic        fault;

    int check_count = 0;
    int pass_count  = 0;
    int cyc         = 0;

    logic [32:0] exp_q[$];
    logic [31:0] instr_q[$];
    logic [31:0] exp_addr;

    typedef struct {
        int          gnt_delay;
        logic [31:0] rdata;
        logic        err;
        logic        trap;
        logic        taken;
        logic [31:0] target;
        logic [31:0] mtvec_v;
        logic [31:0] exp_wdata;
        logic        exp_fault;
    } vec_t;

    rvm_pc_sequencer #(
        .TRAP_ADDR_MASK(32'hFFFF_FFFC)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .pc           (pc),
        .pc_w_en      (pc_w_en),
        .pc_wdata     (pc_wdata),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .imem_err     (imem_err),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_ready  (instr_ready),
        .retire       (retire),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .trap_req     (trap_req),
        .mtvec        (mtvec),
        .fault        (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // PC unit model: resets to zero and captures the sequencer's write.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc <= 32'd0;
        end else if (pc_w_en) begin
            pc <= pc_wdata;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Plays one instruction through memory, decode and execute. It starts at
    // +1 after a clock edge and ends at +1 after the edge that enters UPDATE.
    task automatic applyStimulus(input vec_t v);
        int n;
        int req_cycles;
        exp_q.push_back({v.exp_wdata, v.exp_fault});
        if (!v.err) instr_q.push_back(v.rdata);
        mtvec = v.mtvec_v;

        n = 0;
        while (!imem_req && n < 50) begin
            step();
            n++;
        end
        checkOutput("imem_req_rise", 32'(imem_req), 32'd1);
        checkOutput("imem_addr", imem_addr, exp_addr);

        // Retire/branch/trap noise while fetching must be ignored.
        req_cycles = 0;
        for (int i = 0; i < v.gnt_delay; i++) begin
            if (imem_req) req_cycles++;
            retire        = 1'b1;
            trap_req      = 1'b1;
            branch_taken  = 1'b1;
            branch_target = 32'h0000_0500;
            step();
        end
        retire        = 1'b0;
        trap_req      = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'd0;
        if (imem_req) req_cycles++;
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        if (imem_req) req_cycles++;
        checkOutput("imem_req_cycles", 32'(req_cycles), 32'(v.gnt_delay + 1));

        imem_rvalid = 1'b1;
        imem_rdata  = v.rdata;
        imem_err    = v.err;
        step();
        imem_rvalid = 1'b0;
        imem_err    = 1'b0;
        imem_rdata  = 32'hFFFF_FFFF;

        if (v.err) begin
            checkOutput("err_instr_valid", 32'(instr_valid), 32'd0);
        end else begin
            n = 0;
            while (!instr_valid && n < 50) begin
                step();
                n++;
            end
            checkOutput("instr_valid_rise", 32'(instr_valid), 32'd1);
            instr_ready = 1'b1;
            step();
            instr_ready = 1'b0;
            checkOutput("instr_valid_fall", 32'(instr_valid), 32'd0);
            retire        = 1'b1;
            trap_req      = v.trap;
            branch_taken  = v.taken;
            branch_target = v.target;
            step();
            retire        = 1'b0;
            trap_req      = 1'b0;
            branch_taken  = 1'b0;
            branch_target = 32'h1234_5677;
        end
        checkOutput("pc_w_en", 32'(pc_w_en), 32'd1);
        exp_addr = v.exp_wdata;
    endtask

    // Monitor: compares DUT presentations against the queued expectations.
    initial begin : monitor
        logic        prev_valid;
        logic [32:0] e;
        logic [31:0] ei;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (instr_valid && !prev_valid) begin
                    if (instr_q.size() == 0) begin
                        check_count++;
                        $display("[TB] FAIL instr_unexpected actual=%h required=none", instr);
                    end else begin
                        ei = instr_q.pop_front();
                        checkOutput("instr", instr, ei);
                    end
                end
                if (pc_w_en) begin
                    if (exp_q.size() == 0) begin
                        check_count++;
                        $display("[TB] FAIL pc_w_en_unexpected actual=%h required=none", pc_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("pc_wdata", pc_wdata, e[32:1]);
                        checkOutput("fault", 32'(fault), 32'(e[0]));
                    end
                end else if (fault) begin
                    check_count++;
                    $display("[TB] FAIL fault_without_pc_w_en actual=1 required=0");
                end
            end
            prev_valid = instr_valid;
        end
    end

    vec_t vecs[9];

    initial begin : stimulus
        int rel_cyc;
        vecs[0] = '{0, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,   32'h0000_0004, 1'b0};
        vecs[1] = '{0, 32'h0010_0093, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h0,   32'h0000_0100, 1'b0};
        vecs[2] = '{0, 32'h0020_0113, 1'b0, 1'b0, 1'b1, 32'h0000_0102, 32'h81,  32'h0000_0080, 1'b1};
        vecs[3] = '{0, 32'h0030_0193, 1'b0, 1'b1, 1'b1, 32'h0000_0302, 32'h200, 32'h0000_0200, 1'b0};
        vecs[4] = '{0, 32'h0040_0213, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0,   32'hFFFF_FFFC, 1'b0};
        vecs[5] = '{0, 32'h0050_0293, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,   32'h0000_0000, 1'b0};
        vecs[6] = '{3, 32'hBAD0_BAD0, 1'b1, 1'b0, 1'b0, 32'h0,         32'h40,  32'h0000_0040, 1'b1};
        vecs[7] = '{1, 32'h0060_0313, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,   32'h0000_0044, 1'b0};
        vecs[8] = '{0, 32'h00A0_0093, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,   32'h0000_0004, 1'b0};

        resetn        = 1'b0;
        imem_gnt      = 1'b0;
        imem_rvalid   = 1'b0;
        imem_rdata    = 32'd0;
        imem_err      = 1'b0;
        instr_ready   = 1'b0;
        retire        = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'd0;
        trap_req      = 1'b0;
        mtvec         = 32'd0;
        exp_addr      = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_pc_w_en", 32'(pc_w_en), 32'd0);
        checkOutput("rst_pc_wdata", pc_wdata, 32'd0);
        checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
        checkOutput("rst_imem_addr", imem_addr, 32'd0);
        checkOutput("rst_instr_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_instr", instr, 32'd0);
        checkOutput("rst_fault", 32'(fault), 32'd0);

        resetn  = 1'b1;
        rel_cyc = cyc;
        checkOutput("req_low_at_release", 32'(imem_req), 32'd0);
        applyStimulus(vecs[0]);
        checkOutput("first_loop_cycles", 32'(cyc - rel_cyc), 32'd5);

        for (int i = 1; i < 8; i++) begin
            step();
            applyStimulus(vecs[i]);
        end

        // Reset asserted while waiting for a fetch response.
        step();
        begin : reset_mid_fetch
            int n;
            n = 0;
            while (!imem_req && n < 50) begin
                step();
                n++;
            end
            checkOutput("rst_test_req", 32'(imem_req), 32'd1);
            imem_gnt = 1'b1;
            step();
            imem_gnt = 1'b0;
            #3;
            resetn = 1'b0;
            #1;
            checkOutput("async_imem_req", 32'(imem_req), 32'd0);
            checkOutput("async_pc_w_en", 32'(pc_w_en), 32'd0);
            checkOutput("async_pc_wdata", pc_wdata, 32'd0);
            checkOutput("async_instr_valid", 32'(instr_valid), 32'd0);
            checkOutput("async_instr", instr, 32'd0);
            checkOutput("async_fault", 32'(fault), 32'd0);
            step();
            resetn   = 1'b1;
            exp_addr = 32'd0;
            step();
            // A late response arriving in FETCH is discarded.
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
            step();
            imem_rvalid = 1'b0;
            imem_rdata  = 32'd0;
            checkOutput("late_rvalid_req", 32'(imem_req), 32'd1);
            checkOutput("late_rvalid_valid", 32'(instr_valid), 32'd0);
        end
        applyStimulus(vecs[8]);

        repeat (3) step();
        checkOutput("exp_q_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("instr_q_empty", 32'(instr_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] simulation time limit");
    end

endmodule
